rect_grid_mem: RTL and testbench

- Grid cell store that sits directly downstream of the snake game controller.
- Holds one 4-bit cell type (NULL/SNAKE/ROCK/SNACK) for each cell of the 32x24 play field.
- Accepts the controller's held write word, answers its combinational collision/snack-check reads, and serves a pipelined pixel-lookup port to the VGA rect renderer.
- After reset it sweeps the whole field to NULL before accepting writes.

---
 rtl/rect_grid_mem.sv | 160 ++++++++++++++++
 tb/tb_rect_grid_mem.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/rect_grid_mem.sv
`default_nettype none
// ============================================================================
//  Module   : rect_grid_mem
//  Purpose  : Cell-type store for the 32x24 snake play field. Takes the game
//             controller's held write word, answers its combinational
//             collision/snack reads and feeds the VGA rect renderer through a
//             2-stage pixel lookup. After reset the whole field is swept to
//             NULL before writes are accepted.
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             rect_write[35:0]    - {x[15:0], y[15:0], func[3:0]} held write
//             rect_read_addr[31:0]- {x[15:0], y[15:0]} controller read
//             rect_read_data[3:0] - cell type at rect_read_addr (combinational)
//             hcount, vcount      - renderer pixel coordinate
//             pix_cell[3:0]       - cell type of (hcount, vcount), 2 clocks later
//             busy                - high while the clear sweep runs
//  Revision : 1.0 - initial release
// ============================================================================
module rect_grid_mem #(
   parameter int         GRID_SIZE_X = 32,
   parameter int         GRID_SIZE_Y = 24,
   parameter int         CELL_SHIFT  = 5,
   parameter logic [3:0] OOB_TYPE    = 4'b0010
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [35:0] rect_write,
   input  logic [31:0] rect_read_addr,
   output logic [3:0]  rect_read_data,
   input  logic [10:0] hcount,
   input  logic [10:0] vcount,
   output logic [3:0]  pix_cell,
   output logic        busy
);

   localparam logic [3:0]  C_NULL     = 4'd0;
   localparam logic [9:0]  C_CLR_LAST = 10'(GRID_SIZE_X * GRID_SIZE_Y - 1);
   localparam logic [10:0] C_PIX_W    = 11'(GRID_SIZE_X << CELL_SHIFT);
   localparam logic [10:0] C_PIX_H    = 11'(GRID_SIZE_Y << CELL_SHIFT);

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   state_t      state_q;
   logic [9:0]  clr_addr_q;
   logic        busy_q;

   logic [3:0]  mem_q [0:1023];

   logic [4:0]  pix_x_q;
   logic [4:0]  pix_y_q;
   logic        pix_vld_q;
   logic [3:0]  pix_cell_q;

   // Write-word fields
   logic [15:0] w_wr_x;
   logic [15:0] w_wr_y;
   logic [3:0]  w_wr_func;
   logic        w_wr_valid;

   // Read-address fields
   logic [15:0] w_rd_x;
   logic [15:0] w_rd_y;
   logic        w_rd_valid;

   // Single memory write port shared by the clear sweep and the controller
   logic        w_mem_we;
   logic [9:0]  w_mem_waddr;
   logic [3:0]  w_mem_wdata;

   assign w_wr_x     = rect_write[35:20];
   assign w_wr_y     = rect_write[19:4];
   assign w_wr_func  = rect_write[3:0];
   // Full 16-bit compare so an underflowed coordinate (e.g. 16'hFFFF) is rejected
   assign w_wr_valid = (w_wr_x < 16'(GRID_SIZE_X)) && (w_wr_y < 16'(GRID_SIZE_Y));

   assign w_rd_x     = rect_read_addr[31:16];
   assign w_rd_y     = rect_read_addr[15:0];
   assign w_rd_valid = (w_rd_x < 16'(GRID_SIZE_X)) && (w_rd_y < 16'(GRID_SIZE_Y));

   always_comb begin
      w_mem_we    = 1'b0;
      w_mem_waddr = clr_addr_q;
      w_mem_wdata = C_NULL;
      if (!rst) begin
         if (state_q == ST_CLEAR) begin
            w_mem_we = 1'b1;
         end else if (w_wr_valid) begin
            w_mem_we    = 1'b1;
            w_mem_waddr = {w_wr_y[4:0], w_wr_x[4:0]};
            w_mem_wdata = w_wr_func;
         end
      end
   end

   // Storage has no reset: the sweep below clears it
   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         mem_q[w_mem_waddr] <= w_mem_wdata;
      end
   end

   // Clear/run state machine with registered busy
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_CLEAR;
         clr_addr_q <= 10'd0;
         busy_q     <= 1'b1;
      end else begin
         case (state_q)
            ST_CLEAR: begin
               clr_addr_q <= clr_addr_q + 10'd1;
               if (clr_addr_q == C_CLR_LAST) begin
                  state_q <= ST_RUN;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_RUN;
            end
         endcase
      end
   end

   // Controller read: combinational, sees pre-write content in a write cycle
   always_comb begin
      if (!w_rd_valid) begin
         rect_read_data = OOB_TYPE;
      end else if (state_q == ST_CLEAR) begin
         rect_read_data = C_NULL;
      end else begin
         rect_read_data = mem_q[{w_rd_y[4:0], w_rd_x[4:0]}];
      end
   end

   // Pixel lookup pipeline: stage 1 maps pixel to cell, stage 2 reads the array
   always_ff @(posedge clk) begin
      if (rst) begin
         pix_x_q    <= 5'd0;
         pix_y_q    <= 5'd0;
         pix_vld_q  <= 1'b0;
         pix_cell_q <= C_NULL;
      end else begin
         pix_x_q    <= 5'(hcount >> CELL_SHIFT);
         pix_y_q    <= 5'(vcount >> CELL_SHIFT);
         pix_vld_q  <= (hcount < C_PIX_W) && (vcount < C_PIX_H);
         if (pix_vld_q && (state_q == ST_RUN)) begin
            pix_cell_q <= mem_q[{pix_y_q, pix_x_q}];
         end else begin
            pix_cell_q <= C_NULL;
         end
      end
   end

   assign pix_cell = pix_cell_q;
   assign busy     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_rect_grid_mem.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rect_grid_mem
//  Purpose  : Directed self-checking bench for rect_grid_mem: clear sweep
//             timing, write/read, out-of-range handling, pixel pipeline,
//             same-cycle write/read and reset during the sweep.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rect_grid_mem;

   logic        clk;
   logic        rst;
   logic [35:0] rect_write;
   logic [31:0] rect_read_addr;
   logic [3:0]  rect_read_data;
   logic [10:0] hcount;
   logic [10:0] vcount;
   logic [3:0]  pix_cell;
   logic        busy;

   int n_chk;
   int n_err;

   rect_grid_mem #(
      .GRID_SIZE_X (32),
      .GRID_SIZE_Y (24),
      .CELL_SHIFT  (5),
      .OOB_TYPE    (4'b0010)
   ) u_dut (
      .clk            (clk),
      .rst            (rst),
      .rect_write     (rect_write),
      .rect_read_addr (rect_read_addr),
      .rect_read_data (rect_read_data),
      .hcount         (hcount),
      .vcount         (vcount),
      .pix_cell       (pix_cell),
      .busy           (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Step to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_wr(input logic [15:0] x, input logic [15:0] y, input logic [3:0] f);
      rect_write = {x, y, f};
   endtask

   task automatic set_rd(input logic [15:0] x, input logic [15:0] y);
      rect_read_addr = {x, y};
   endtask

   // Count cells whose content differs from 0, except one cell expected to hold ex_v
   task automatic scan(input string tag, input int ex_x, input int ex_y, input logic [3:0] ex_v);
      int bad;
      logic [3:0] exp;
      bad = 0;
      for (int y = 0; y < 24; y++) begin
         for (int x = 0; x < 32; x++) begin
            set_rd(16'(x), 16'(y));
            #1;
            exp = (x == ex_x && y == ex_y) ? ex_v : 4'd0;
            if (rect_read_data !== exp) bad++;
         end
      end
      chk(tag, 32'(bad), 32'd0);
   endtask

   // Wait for busy to drop; returns the number of cycles it stayed high
   task automatic wait_sweep(output int cnt);
      cnt = 0;
      while (cnt < 2000) begin
         tick();
         cnt++;
         if (!busy) break;
      end
   endtask

   initial begin
      int cnt;
      int bad;
      logic [3:0] exp;
      n_chk = 0;
      n_err = 0;

      rst    = 1'b1;
      hcount = 11'd0;
      vcount = 11'd0;
      set_wr(16'd15, 16'd15, 4'b0001);
      set_rd(16'd15, 16'd15);
      repeat (3) tick();
      chk("rst_busy", 32'(busy), 32'd1);
      chk("rst_pix", 32'(pix_cell), 32'd0);

      // First sweep with the SNAKE write held throughout
      rst = 1'b0;
      cnt = 0;
      while (cnt < 2000) begin
         tick();
         cnt++;
         if (cnt == 100) chk("clr_read", 32'(rect_read_data), 32'd0);
         if (!busy) break;
      end
      chk("sweep_len", 32'(cnt), 32'd768);
      #1;
      chk("held_wr_not_yet", 32'(rect_read_data), 32'd0);
      tick();
      chk("held_wr_applied", 32'(rect_read_data), 32'd1);
      set_wr(16'hFFFF, 16'hFFFF, 4'b1111);
      scan("scan_after_sweep", 15, 15, 4'b0001);

      // Write / read
      set_wr(16'd5, 16'd7, 4'b0001);
      tick();
      set_rd(16'd5, 16'd7);
      #1 chk("rd_5_7", 32'(rect_read_data), 32'd1);
      set_rd(16'd5, 16'd8);
      #1 chk("rd_5_8", 32'(rect_read_data), 32'd0);
      set_wr(16'd5, 16'd7, 4'b0000);
      tick();
      set_rd(16'd5, 16'd7);
      #1 chk("rd_5_7_clr", 32'(rect_read_data), 32'd0);

      // Out of range
      set_rd(16'hFFFF, 16'd0);
      #1 chk("oob_xneg", 32'(rect_read_data), 32'd2);
      set_rd(16'd32, 16'd0);
      #1 chk("oob_x32", 32'(rect_read_data), 32'd2);
      set_rd(16'd0, 16'd24);
      #1 chk("oob_y24", 32'(rect_read_data), 32'd2);
      set_rd(16'd31, 16'd23);
      #1 chk("edge_31_23", 32'(rect_read_data), 32'd0);
      set_wr(16'd32, 16'd0, 4'b0100);
      tick();
      set_wr(16'hFFFF, 16'hFFFF, 4'b1111);
      set_rd(16'd0, 16'd0);
      #1 chk("oob_wr_drop", 32'(rect_read_data), 32'd0);

      // Pixel port: cell (3,2) = SNACK, pixel (100,70)
      set_wr(16'd3, 16'd2, 4'b0100);
      tick();
      set_wr(16'hFFFF, 16'hFFFF, 4'b1111);
      hcount = 11'd100;
      vcount = 11'd70;
      tick();
      chk("pix_lat1", 32'(pix_cell), 32'd0);
      tick();
      chk("pix_lat2", 32'(pix_cell), 32'd4);
      hcount = 11'd1124;   // same cell bits as 100 but off-screen
      tick();
      tick();
      chk("pix_offscreen", 32'(pix_cell), 32'd0);

      // Row 0 pattern then a streaming hcount ramp
      for (int x = 0; x < 32; x++) begin
         set_wr(16'(x), 16'd0, 4'((x * 3 + 1) & 15));
         tick();
      end
      set_wr(16'hFFFF, 16'hFFFF, 4'b1111);
      vcount = 11'd0;
      bad = 0;
      for (int i = 0; i <= 1024; i++) begin
         hcount = 11'(i);
         tick();
         if (i >= 1) begin
            exp = 4'((((i - 1) >> 5) * 3 + 1) & 15);
            if (pix_cell !== exp) bad++;
         end
      end
      chk("pix_ramp", 32'(bad), 32'd0);

      // Same-cycle write and read of (1,1)
      set_wr(16'd1, 16'd1, 4'b0010);
      set_rd(16'd1, 16'd1);
      #1 chk("same_cyc_old", 32'(rect_read_data), 32'd0);
      tick();
      chk("same_cyc_new", 32'(rect_read_data), 32'd2);
      set_wr(16'hFFFF, 16'hFFFF, 4'b1111);

      // Reset, then reset again in the middle of the sweep
      hcount = 11'd100;
      vcount = 11'd70;
      set_rd(16'd31, 16'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 1; i <= 300; i++) begin
         tick();
         if (i == 10) begin
            chk("clr_pix_forced", 32'(pix_cell), 32'd0);
            chk("clr_rd_forced", 32'(rect_read_data), 32'd0);
         end
      end
      chk("mid_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      wait_sweep(cnt);
      chk("resweep_len", 32'(cnt), 32'd768);
      scan("scan_after_resweep", 0, 0, 4'b0000);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
`default_nettype wire
